traffic_fsm: RTL and testbench

- Highway/farm-road intersection controller. It is the consumer side of the timer interface.
- Samples short_timeout and long_timeout from the intersection timer plus a farm-road car sensor.
- Drives the highway and farm-road light outputs.
- Issues single-cycle timer_hw_reset / timer_fw_reset pulses to restart the timer on every phase change.

---
 rtl/traffic_fsm.sv | 181 ++++++++++++++++++
 tb/tb_traffic_fsm.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_fsm.sv
// traffic_fsm: highway / farm-road intersection controller.
//
// Consumes the level-type short/long timeouts from the intersection timer and
// a farm-road car sensor, drives both light heads and restarts the timer with a
// one-cycle pulse on every phase change.
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   reset           synchronous, active-high reset
//   car_sensor      farm-road car present (asynchronous to clk)
//   short_timeout   timer short interval elapsed (level)
//   long_timeout    timer long interval elapsed (level)
//   timer_hw_reset  registered pulse: timer restart on highway-side phase entry
//   timer_fw_reset  registered pulse: timer restart on farm-side phase entry
//   hw_light        highway light code
//   fw_light        farm-road light code
//   ctrl_state      current state code (debug)
module traffic_fsm #(
  parameter logic [1:0] LIGHT_GREEN   = 2'd0,
  parameter logic [1:0] LIGHT_YELLOW  = 2'd1,
  parameter logic [1:0] LIGHT_RED     = 2'd2,
  parameter int         USE_CLEARANCE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_sensor,
  input  logic       short_timeout,
  input  logic       long_timeout,
  output logic       timer_hw_reset,
  output logic       timer_fw_reset,
  output logic [1:0] hw_light,
  output logic [1:0] fw_light,
  output logic [2:0] ctrl_state
);

  typedef enum logic [2:0] {
    ST_HG    = 3'd0,
    ST_HY    = 3'd1,
    ST_AR_HF = 3'd2,
    ST_FG    = 3'd3,
    ST_FY    = 3'd4,
    ST_AR_FH = 3'd5
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   recover_s;
  logic   hw_pulse_s;
  logic   fw_pulse_s;
  logic   entry_r;
  logic   car_meta_r;
  logic   car_sync_r;
  logic   car_pending_r;

  // Highway light code shown in a given state.
  function automatic logic [1:0] hw_light_of(input state_t s);
    logic [1:0] l;
    case (s)
      ST_HG:   l = LIGHT_GREEN;
      ST_HY:   l = LIGHT_YELLOW;
      default: l = LIGHT_RED;
    endcase
    return l;
  endfunction

  // Farm-road light code shown in a given state.
  function automatic logic [1:0] fw_light_of(input state_t s);
    logic [1:0] l;
    case (s)
      ST_FG:   l = LIGHT_GREEN;
      ST_FY:   l = LIGHT_YELLOW;
      default: l = LIGHT_RED;
    endcase
    return l;
  endfunction

  // Next-state decision. While a timer pulse is high (entry_r) the timeouts
  // still reflect the previous phase, so every transition is masked.
  always_comb begin
    next_state_s = state_r;
    recover_s    = 1'b0;
    case (state_r)
      ST_HG: begin
        // car_pending_r is the registered flag: a car first seen on this
        // same edge does not count yet.
        if (!entry_r && long_timeout && car_pending_r) next_state_s = ST_HY;
        else                                           next_state_s = state_r;
      end
      ST_HY: begin
        if (!entry_r && short_timeout)
          next_state_s = (USE_CLEARANCE != 0) ? ST_AR_HF : ST_FG;
        else
          next_state_s = state_r;
      end
      ST_AR_HF: begin
        if (!entry_r && short_timeout) next_state_s = ST_FG;
        else                           next_state_s = state_r;
      end
      ST_FG: begin
        // Long timeout ends the phase regardless of car_sync; the short
        // timeout ends it early once the farm road has emptied.
        if (!entry_r && (long_timeout || (short_timeout && !car_sync_r)))
          next_state_s = ST_FY;
        else
          next_state_s = state_r;
      end
      ST_FY: begin
        if (!entry_r && short_timeout)
          next_state_s = (USE_CLEARANCE != 0) ? ST_AR_FH : ST_HG;
        else
          next_state_s = state_r;
      end
      ST_AR_FH: begin
        if (!entry_r && short_timeout) next_state_s = ST_HG;
        else                           next_state_s = state_r;
      end
      default: begin
        // Unused codes 6/7: recover to HG and restart the timer from both sides.
        next_state_s = ST_HG;
        recover_s    = 1'b1;
      end
    endcase
  end

  // Timer restart pulse selection for the state being entered.
  always_comb begin
    hw_pulse_s = 1'b0;
    fw_pulse_s = 1'b0;
    if (recover_s) begin
      hw_pulse_s = 1'b1;
      fw_pulse_s = 1'b1;
    end else if (next_state_s != state_r) begin
      case (next_state_s)
        ST_HG, ST_HY, ST_AR_HF: hw_pulse_s = 1'b1;
        ST_FG, ST_FY, ST_AR_FH: fw_pulse_s = 1'b1;
        default: begin
          hw_pulse_s = 1'b0;
          fw_pulse_s = 1'b0;
        end
      endcase
    end else begin
      hw_pulse_s = 1'b0;
      fw_pulse_s = 1'b0;
    end
  end

  // State, lights, timer pulses, car synchronizer and pending-car flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_HG;
      hw_light       <= LIGHT_GREEN;
      fw_light       <= LIGHT_RED;
      timer_hw_reset <= 1'b0;
      timer_fw_reset <= 1'b0;
      entry_r        <= 1'b0;
      car_meta_r     <= 1'b0;
      car_sync_r     <= 1'b0;
      car_pending_r  <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      hw_light       <= hw_light_of(next_state_s);
      fw_light       <= fw_light_of(next_state_s);
      timer_hw_reset <= hw_pulse_s;
      timer_fw_reset <= fw_pulse_s;
      entry_r        <= hw_pulse_s | fw_pulse_s;
      car_meta_r     <= car_sensor;
      car_sync_r     <= car_meta_r;
      // Serving the farm road consumes the request; a car seen on any other
      // edge (re)arms it.
      if ((next_state_s == ST_FG) && (state_r != ST_FG))
        car_pending_r <= 1'b0;
      else if (car_sync_r)
        car_pending_r <= 1'b1;
      else
        car_pending_r <= car_pending_r;
    end
  end

  assign ctrl_state = state_r;

endmodule

// File: tb/tb_traffic_fsm.sv
// Testbench for traffic_fsm: two instances (with and without all-red
// clearance), each driven by its own behavioural model of the intersection
// timer (count restarts on a pulse, short = count>=3, long = count>=7).
module tb_traffic_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: USE_CLEARANCE = 1
  logic       reset1 = 1'b1, car1 = 1'b0;
  logic       short1, long1, hwp1, fwp1;
  logic [1:0] hw1, fw1;
  logic [2:0] st1;
  logic [3:0] cnt1;

  // Instance 0: USE_CLEARANCE = 0
  logic       reset0 = 1'b1, car0 = 1'b0;
  logic       short0, long0, hwp0, fwp0;
  logic [1:0] hw0, fw0;
  logic [2:0] st0;
  logic [3:0] cnt0;

  int n_checks = 0;
  int n_fail   = 0;
  bit seen_ar0 = 1'b0;

  traffic_fsm #(.USE_CLEARANCE(1)) dut1 (
    .clk(clk), .reset(reset1), .car_sensor(car1),
    .short_timeout(short1), .long_timeout(long1),
    .timer_hw_reset(hwp1), .timer_fw_reset(fwp1),
    .hw_light(hw1), .fw_light(fw1), .ctrl_state(st1)
  );

  traffic_fsm #(.USE_CLEARANCE(0)) dut0 (
    .clk(clk), .reset(reset0), .car_sensor(car0),
    .short_timeout(short0), .long_timeout(long0),
    .timer_hw_reset(hwp0), .timer_fw_reset(fwp0),
    .hw_light(hw0), .fw_light(fw0), .ctrl_state(st0)
  );

  // Timer models
  always @(posedge clk) begin
    if (reset1 || hwp1 || fwp1) cnt1 <= 4'd0;
    else if (cnt1 != 4'd15)     cnt1 <= cnt1 + 4'd1;
  end
  always @(posedge clk) begin
    if (reset0 || hwp0 || fwp0) cnt0 <= 4'd0;
    else if (cnt0 != 4'd15)     cnt0 <= cnt0 + 4'd1;
  end
  assign short1 = (cnt1 >= 4'd3);
  assign long1  = (cnt1 >= 4'd7);
  assign short0 = (cnt0 >= 4'd3);
  assign long0  = (cnt0 >= 4'd7);

  // Watch for any all-red code on the no-clearance instance
  always @(negedge clk) begin
    if (!reset0 && (st0 == 3'd2 || st0 == 3'd5)) seen_ar0 = 1'b1;
  end

  // Expected phase sequences: state, cycles since previous entry, pulse side, lights
  localparam logic [2:0] FC_ST  [0:6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
  localparam int         FC_DUR [0:6] = '{8, 5, 5, 9, 5, 5, 9};
  localparam logic       FC_HWS [0:6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [1:0] FC_HW  [0:6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
  localparam logic [1:0] FC_FW  [0:6] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2};

  localparam logic [2:0] NC_ST  [0:4] = '{3'd1, 3'd3, 3'd4, 3'd0, 3'd1};
  localparam int         NC_DUR [0:4] = '{8, 5, 9, 5, 9};
  localparam logic       NC_HWS [0:4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [1:0] NC_HW  [0:4] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
  localparam logic [1:0] NC_FW  [0:4] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset1(input int n);
    reset1 = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset1 = 1'b0;
  endtask

  task automatic do_reset0(input int n);
    reset0 = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset0 = 1'b0;
  endtask

  // Step until st1 == target or budget cycles elapse; returns cycles stepped.
  task automatic wait_state1(input logic [2:0] target, input int budget, output int cyc);
    cyc = 0;
    while (st1 !== target && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_state0(input logic [2:0] target, input int budget, output int cyc);
    cyc = 0;
    while (st0 !== target && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    car1 = 1'b0;
    do_reset1(3);
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if ({st1, hw1, fw1, hwp1, fwp1} !== {3'd0, 2'd0, 2'd2, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: state=%0d hw=%0d fw=%0d hwp=%b fwp=%b, required state=0 hw=0 fw=2 hwp=0 fwp=0",
                 i, st1, hw1, fw1, hwp1, fwp1);
      end
      tick();
    end
  endtask

  task automatic test_car_latch();
    int cyc;
    do_reset1(3);
    car1 = 1'b1;
    tick();
    car1 = 1'b0;
    repeat (6) tick();
    // Seven cycles after release: still HG, request latched
    n_checks++;
    if (st1 !== 3'd0 || dut1.car_pending_r !== 1'b1) begin
      n_fail++;
      $display("FAIL car_latch: state=%0d pending=%b, required state=0 pending=1", st1, dut1.car_pending_r);
    end
    tick();
    n_checks++;
    if (st1 !== 3'd1 || hwp1 !== 1'b1 || fwp1 !== 1'b0 || hw1 !== 2'd1 || fw1 !== 2'd2) begin
      n_fail++;
      $display("FAIL hy_entry: state=%0d hwp=%b fwp=%b hw=%0d fw=%0d, required 1 1 0 1 2", st1, hwp1, fwp1, hw1, fw1);
    end
    tick();
    n_checks++;
    if (hwp1 !== 1'b0 || fwp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL hy_pulse_width: hwp=%b fwp=%b, required 0 0", hwp1, fwp1);
    end
    wait_state1(3'd2, 40, cyc);
    n_checks++;
    if (cyc + 1 !== 5) begin
      n_fail++;
      $display("FAIL hy_dwell: %0d cycles, required 5", cyc + 1);
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    do_reset1(3);
    repeat (5) tick();
    car1 = 1'b1;
    tick();
    car1 = 1'b0;
    // car_sync first high on the edge that samples long: one extra HG cycle
    wait_state1(3'd1, 40, cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_fail++;
      $display("FAIL hg_same_edge_car: HY after %0d cycles, required 3", cyc);
    end
  endtask

  task automatic test_full_cycle();
    int cyc;
    int pre;
    pre = 0;
    car1 = 1'b1;
    do_reset1(3);
    for (int i = 0; i < 7; i++) begin
      wait_state1(FC_ST[i], 40, cyc);
      n_checks++;
      if (cyc + pre !== FC_DUR[i]) begin
        n_fail++;
        $display("FAIL full_dwell step %0d: %0d cycles, required %0d", i, cyc + pre, FC_DUR[i]);
      end
      n_checks++;
      if ({st1, hwp1, fwp1, hw1, fw1} !== {FC_ST[i], FC_HWS[i], ~FC_HWS[i], FC_HW[i], FC_FW[i]}) begin
        n_fail++;
        $display("FAIL full_entry step %0d: state=%0d hwp=%b fwp=%b hw=%0d fw=%0d, required %0d %b %b %0d %0d",
                 i, st1, hwp1, fwp1, hw1, fw1, FC_ST[i], FC_HWS[i], ~FC_HWS[i], FC_HW[i], FC_FW[i]);
      end
      tick();
      pre = 1;
      n_checks++;
      if (hwp1 !== 1'b0 || fwp1 !== 1'b0) begin
        n_fail++;
        $display("FAIL full_pulse_width step %0d: hwp=%b fwp=%b, required 0 0", i, hwp1, fwp1);
      end
    end
    car1 = 1'b0;
  endtask

  task automatic test_fg_early_exit();
    int cyc;
    car1 = 1'b1;
    do_reset1(3);
    wait_state1(3'd3, 60, cyc);
    n_checks++;
    if (st1 !== 3'd3 || dut1.car_pending_r !== 1'b0) begin
      n_fail++;
      $display("FAIL fg_entry_clear: state=%0d pending=%b, required 3 0", st1, dut1.car_pending_r);
    end
    car1 = 1'b0;
    wait_state1(3'd4, 40, cyc);
    n_checks++;
    if (cyc !== 5) begin
      n_fail++;
      $display("FAIL fg_early_exit: FY after %0d cycles, required 5", cyc);
    end
  endtask

  task automatic test_no_clearance();
    int cyc;
    int pre;
    pre = 0;
    car0 = 1'b1;
    do_reset0(3);
    seen_ar0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_state0(NC_ST[i], 40, cyc);
      n_checks++;
      if (cyc + pre !== NC_DUR[i]) begin
        n_fail++;
        $display("FAIL nc_dwell step %0d: %0d cycles, required %0d", i, cyc + pre, NC_DUR[i]);
      end
      n_checks++;
      if ({st0, hwp0, fwp0, hw0, fw0} !== {NC_ST[i], NC_HWS[i], ~NC_HWS[i], NC_HW[i], NC_FW[i]}) begin
        n_fail++;
        $display("FAIL nc_entry step %0d: state=%0d hwp=%b fwp=%b hw=%0d fw=%0d, required %0d %b %b %0d %0d",
                 i, st0, hwp0, fwp0, hw0, fw0, NC_ST[i], NC_HWS[i], ~NC_HWS[i], NC_HW[i], NC_FW[i]);
      end
      tick();
      pre = 1;
    end
    n_checks++;
    if (seen_ar0 !== 1'b0) begin
      n_fail++;
      $display("FAIL nc_no_all_red: all-red seen=%b, required 0", seen_ar0);
    end
    car0 = 1'b0;
  endtask

  task automatic test_reset_mid_phase();
    int cyc;
    car1 = 1'b1;
    do_reset1(3);
    wait_state1(3'd4, 80, cyc);
    n_checks++;
    if (st1 !== 3'd4 || fwp1 !== 1'b1) begin
      n_fail++;
      $display("FAIL fy_reached: state=%0d fwp=%b, required 4 1", st1, fwp1);
    end
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    n_checks++;
    if ({st1, hw1, fw1, hwp1, fwp1, dut1.car_pending_r} !== {3'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_fy: state=%0d hw=%0d fw=%0d hwp=%b fwp=%b pending=%b, required 0 0 2 0 0 0",
               st1, hw1, fw1, hwp1, fwp1, dut1.car_pending_r);
    end
    car1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_car_latch();
    test_simultaneous();
    test_full_cycle();
    test_fg_early_exit();
    test_no_clearance();
    test_reset_mid_phase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
